// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the write-back stage.
//   RegWriteSelect : RF data source
//   R7WriteSelect  : R7/PC data source (1xx decodes as PCInc)
//   Flag bit indices inside the 2-bit condition-code register
package writeback_stage_pkg;

  localparam int PC_REG    = 7;
  localparam int CARRY_BIT = 1;
  localparam int ZERO_BIT  = 0;

  typedef enum logic [1:0] {
    SEL_ALU   = 2'b00,
    SEL_MEM   = 2'b01,
    SEL_LHI   = 2'b10,
    SEL_PCINC = 2'b11
  } regSel_e;

  typedef enum logic [2:0] {
    R7_PCINC  = 3'b000,
    R7_TARGET = 3'b001,
    R7_ALU    = 3'b010,
    R7_MEM    = 3'b011
  } r7Sel_e;

endpackage

// File: rtl/wb_flag_unit.sv
// Architectural condition-code register.
//   clk, reset : clock, async active-high reset
//   update     : a valid instruction requests a flag update
//   loadSrc    : the instruction's RF source is memory (load)
//   memData    : load data, used only for the zero flag on loads
//   ccrIn      : upstream flags {carry, zero}
//   ccrQ       : architectural flags {carry, zero}
module wb_flag_unit
  import writeback_stage_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          update,
  input  logic          loadSrc,
  input  logic [DW-1:0] memData,
  input  logic [1:0]    ccrIn,
  output logic [1:0]    ccrQ
);

  // Loads recompute zero from the loaded value and leave carry untouched;
  // every other flag-writing instruction takes the upstream flags whole.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ccrQ <= 2'b00;
    end else if (update) begin
      if (loadSrc) ccrQ[ZERO_BIT] <= (memData == '0);
      else         ccrQ           <= ccrIn;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: turns the registered WB bundle into RF, R7/PC and flag
// updates, keeps a one-entry forwarding latch and a retired-instruction count.
//   Inputs : clk, reset, wb_valid, data sources (MemData, Imm970s, PCImmInc,
//            ALUOut, PCInc), WriteAdd, WriteRF, WriteR7, RegWriteSelect,
//            R7WriteSelect, CCR, CCRWrite
//   Outputs: rf_wr/rf_wa/rf_wd (combinational), r7_wr/r7_wd (combinational),
//            ccr_q, fwd_valid/fwd_addr/fwd_data, retire_count (registered)
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 3,
  parameter int PC_REG = writeback_stage_pkg::PC_REG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [DW-1:0] MemData,
  input  logic [DW-1:0] Imm970s,
  input  logic [DW-1:0] PCImmInc,
  input  logic [DW-1:0] ALUOut,
  input  logic [DW-1:0] PCInc,
  input  logic [AW-1:0] WriteAdd,
  input  logic          WriteRF,
  input  logic          WriteR7,
  input  logic [1:0]    RegWriteSelect,
  input  logic [2:0]    R7WriteSelect,
  input  logic [1:0]    CCR,
  input  logic          CCRWrite,
  output logic          rf_wr,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          r7_wr,
  output logic [DW-1:0] r7_wd,
  output logic [1:0]    ccr_q,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic [15:0]   retire_count
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

  logic          live;      // real instruction, not squashed by reset
  logic          toPc;      // RF write aimed at the PC alias
  logic [DW-1:0] r7Mux;

  assign live = wb_valid & ~reset;
  assign toPc = WriteAdd == PC_ADDR;

  always_comb begin
    rf_wd = ALUOut;
    case (RegWriteSelect)
      SEL_ALU:   rf_wd = ALUOut;
      SEL_MEM:   rf_wd = MemData;
      SEL_LHI:   rf_wd = Imm970s;
      SEL_PCINC: rf_wd = PCInc;
      default:   rf_wd = ALUOut;
    endcase
  end

  // Upper half of the R7 select space is unused and falls back to PCInc.
  always_comb begin
    r7Mux = PCInc;
    case (R7WriteSelect)
      R7_PCINC:  r7Mux = PCInc;
      R7_TARGET: r7Mux = PCImmInc;
      R7_ALU:    r7Mux = ALUOut;
      R7_MEM:    r7Mux = MemData;
      default:   r7Mux = PCInc;
    endcase
  end

  assign rf_wa = WriteAdd;
  assign rf_wr = live & WriteRF & ~toPc;

  // An RF write to R7 is redirected to the PC port and beats WriteR7.
  assign r7_wr = live & ((WriteRF & toPc) | WriteR7);
  assign r7_wd = (WriteRF & toPc) ? rf_wd : r7Mux;

  wb_flag_unit #(.DW(DW)) uFlags (
    .clk     (clk),
    .reset   (reset),
    .update  (wb_valid & CCRWrite),
    .loadSrc (RegWriteSelect == SEL_MEM),
    .memData (MemData),
    .ccrIn   (CCR),
    .ccrQ    (ccr_q)
  );

  // Forwarding latch only tracks R0..R6 writes; addr/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= rf_wr;
      if (rf_wr) begin
        fwd_addr <= WriteAdd;
        fwd_data <= rf_wd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         retire_count <= 16'h0000;
    else if (wb_valid) retire_count <= retire_count + 16'd1;
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [15:0] MemData, Imm970s, PCImmInc, ALUOut, PCInc;
  logic [2:0]  WriteAdd;
  logic        WriteRF, WriteR7;
  logic [1:0]  RegWriteSelect;
  logic [2:0]  R7WriteSelect;
  logic [1:0]  CCR;
  logic        CCRWrite;
  logic        rf_wr;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;
  logic        r7_wr;
  logic [15:0] r7_wd;
  logic [1:0]  ccr_q;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic [15:0] retire_count;

  int chk = 0;
  int err = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid),
    .MemData(MemData), .Imm970s(Imm970s), .PCImmInc(PCImmInc),
    .ALUOut(ALUOut), .PCInc(PCInc), .WriteAdd(WriteAdd),
    .WriteRF(WriteRF), .WriteR7(WriteR7), .RegWriteSelect(RegWriteSelect),
    .R7WriteSelect(R7WriteSelect), .CCR(CCR), .CCRWrite(CCRWrite),
    .rf_wr(rf_wr), .rf_wa(rf_wa), .rf_wd(rf_wd), .r7_wr(r7_wr), .r7_wd(r7_wd),
    .ccr_q(ccr_q), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retire_count(retire_count)
  );

  task automatic idle();
    wb_valid = 0; MemData = 0; Imm970s = 0; PCImmInc = 0; ALUOut = 0; PCInc = 0;
    WriteAdd = 0; WriteRF = 0; WriteR7 = 0; RegWriteSelect = 0;
    R7WriteSelect = 0; CCR = 0; CCRWrite = 0;
  endtask

  // Advance one edge; inputs are then changed / outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; idle(); tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    chk++; if (ccr_q !== 2'b00) begin err++; $display("FAIL rst_ccr got %h exp 0", ccr_q); end
    chk++; if (retire_count !== 16'h0) begin err++; $display("FAIL rst_cnt got %h exp 0", retire_count); end
    // build up some state, then hit reset mid-cycle with a live bundle
    wb_valid = 1; WriteRF = 1; WriteAdd = 5; ALUOut = 16'h0077; CCRWrite = 1; CCR = 2'b11;
    tick(); tick();
    chk++; if (retire_count !== 16'h2) begin err++; $display("FAIL rst_pre_cnt got %h exp 2", retire_count); end
    WriteR7 = 1;
    #2 reset = 1; #1;
    chk++; if (ccr_q !== 2'b00) begin err++; $display("FAIL rst_async_ccr got %h exp 0", ccr_q); end
    chk++; if ({fwd_valid, fwd_addr, fwd_data} !== 20'h0) begin err++; $display("FAIL rst_async_fwd got %b %h %h exp 0", fwd_valid, fwd_addr, fwd_data); end
    chk++; if (retire_count !== 16'h0) begin err++; $display("FAIL rst_async_cnt got %h exp 0", retire_count); end
    chk++; if ({rf_wr, r7_wr} !== 2'b00) begin err++; $display("FAIL rst_async_wr got %b%b exp 00", rf_wr, r7_wr); end
    tick();  // edge while reset is high: the bundle must be dropped
    chk++; if ({ccr_q, fwd_valid, retire_count} !== 19'h0) begin err++; $display("FAIL rst_hold got %h %b %h exp 0", ccr_q, fwd_valid, retire_count); end
    reset = 0; idle(); tick();
  endtask

  task automatic test_alu_write();
    wb_valid = 1; WriteRF = 1; WriteAdd = 3; RegWriteSelect = 2'b00; ALUOut = 16'h1234;
    MemData = 16'hBEEF; CCRWrite = 1; CCR = 2'b10; #1;
    chk++; if (rf_wr !== 1'b1) begin err++; $display("FAIL alu_rf_wr got %b exp 1", rf_wr); end
    chk++; if (rf_wa !== 3'd3) begin err++; $display("FAIL alu_rf_wa got %0d exp 3", rf_wa); end
    chk++; if (rf_wd !== 16'h1234) begin err++; $display("FAIL alu_rf_wd got %h exp 1234", rf_wd); end
    chk++; if (r7_wr !== 1'b0) begin err++; $display("FAIL alu_r7_wr got %b exp 0", r7_wr); end
    chk++; if (fwd_valid !== 1'b0) begin err++; $display("FAIL alu_fwd_early got %b exp 0", fwd_valid); end
    tick();
    chk++; if (ccr_q !== 2'b10) begin err++; $display("FAIL alu_ccr got %b exp 10", ccr_q); end
    chk++; if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 3'd3, 16'h1234}) begin err++; $display("FAIL alu_fwd got %b %0d %h exp 1 3 1234", fwd_valid, fwd_addr, fwd_data); end
    chk++; if (retire_count !== 16'h1) begin err++; $display("FAIL alu_cnt got %h exp 1", retire_count); end
  endtask

  task automatic test_load_zero();
    // CCR input deliberately differs so a load that copied CCR is caught
    wb_valid = 1; WriteRF = 1; WriteAdd = 2; RegWriteSelect = 2'b01; MemData = 16'h0000;
    ALUOut = 16'h0000; CCRWrite = 1; CCR = 2'b00; #1;
    chk++; if (rf_wd !== 16'h0000) begin err++; $display("FAIL ld_wd got %h exp 0", rf_wd); end
    tick();
    chk++; if (ccr_q !== 2'b11) begin err++; $display("FAIL ld_zero_ccr got %b exp 11", ccr_q); end
    MemData = 16'h0005; CCR = 2'b01; tick();
    chk++; if (ccr_q !== 2'b10) begin err++; $display("FAIL ld_nz_ccr got %b exp 10", ccr_q); end
    chk++; if ({fwd_addr, fwd_data} !== {3'd2, 16'h0005}) begin err++; $display("FAIL ld_fwd got %0d %h exp 2 0005", fwd_addr, fwd_data); end
  endtask

  task automatic test_r7_redirect();
    idle();
    wb_valid = 1; WriteRF = 1; WriteAdd = 7; RegWriteSelect = 2'b11; PCInc = 16'h0042;
    PCImmInc = 16'h9999; WriteR7 = 1; R7WriteSelect = 3'b001; #1;
    chk++; if ({rf_wr, r7_wr} !== 2'b01) begin err++; $display("FAIL r7_redir_wr got %b%b exp 01", rf_wr, r7_wr); end
    chk++; if (r7_wd !== 16'h0042) begin err++; $display("FAIL r7_redir_wd got %h exp 0042", r7_wd); end
    tick();
    chk++; if ({fwd_valid, fwd_addr, fwd_data} !== {1'b0, 3'd2, 16'h0005}) begin err++; $display("FAIL r7_fwd got %b %0d %h exp 0 2 0005", fwd_valid, fwd_addr, fwd_data); end
    WriteRF = 0; #1;
    chk++; if ({r7_wr, r7_wd} !== {1'b1, 16'h9999}) begin err++; $display("FAIL r7_target got %b %h exp 1 9999", r7_wr, r7_wd); end
    R7WriteSelect = 3'b110; #1;
    chk++; if (r7_wd !== 16'h0042) begin err++; $display("FAIL r7_1xx got %h exp 0042", r7_wd); end
    tick();
  endtask

  task automatic test_bubble();
    logic [15:0] cnt0;
    idle();
    wb_valid = 1; WriteRF = 1; WriteAdd = 4; RegWriteSelect = 2'b10; Imm970s = 16'hABCD;
    CCRWrite = 1; CCR = 2'b01; tick();
    cnt0 = retire_count;
    chk++; if ({ccr_q, fwd_valid} !== 3'b011) begin err++; $display("FAIL bub_pre got %b %b exp 01 1", ccr_q, fwd_valid); end
    wb_valid = 0; WriteR7 = 1; CCR = 2'b10; WriteAdd = 1; #1;
    chk++; if ({rf_wr, r7_wr} !== 2'b00) begin err++; $display("FAIL bub_wr got %b%b exp 00", rf_wr, r7_wr); end
    tick();
    chk++; if (ccr_q !== 2'b01) begin err++; $display("FAIL bub_ccr got %b exp 01", ccr_q); end
    chk++; if (retire_count !== cnt0) begin err++; $display("FAIL bub_cnt got %h exp %h", retire_count, cnt0); end
    chk++; if ({fwd_valid, fwd_addr, fwd_data} !== {1'b0, 3'd4, 16'hABCD}) begin err++; $display("FAIL bub_fwd got %b %0d %h exp 0 4 abcd", fwd_valid, fwd_addr, fwd_data); end
  endtask

  // Reference model: instruction-level semantics, state kept as plain vars.
  task automatic test_random();
    logic [15:0] src [4];
    logic [15:0] r7src [4];
    logic [1:0]  mCcr;
    logic        mFv;
    logic [2:0]  mFa;
    logic [15:0] mFd, mCnt, eWd, eR7d;
    logic        eRf, eR7, isRfPc;
    do_reset();
    mCcr = 0; mFv = 0; mFa = 0; mFd = 0; mCnt = 0;
    for (int n = 0; n < 400; n++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      MemData = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      Imm970s = 16'($urandom); PCImmInc = 16'($urandom);
      ALUOut = 16'($urandom); PCInc = 16'($urandom);
      WriteAdd = 3'($urandom); WriteRF = 1'($urandom); WriteR7 = 1'($urandom);
      RegWriteSelect = 2'($urandom); R7WriteSelect = 3'($urandom);
      CCR = 2'($urandom); CCRWrite = 1'($urandom);
      #1;
      src   = '{ALUOut, MemData, Imm970s, PCInc};
      r7src = '{PCInc, PCImmInc, ALUOut, MemData};
      eWd = src[RegWriteSelect];
      isRfPc = WriteRF && WriteAdd == 3'd7;
      eRf = wb_valid && WriteRF && !isRfPc;
      eR7 = wb_valid && (isRfPc || WriteR7);
      eR7d = isRfPc ? eWd : (R7WriteSelect >= 3'd4 ? PCInc : r7src[R7WriteSelect[1:0]]);
      chk++; if ({rf_wr, rf_wa, rf_wd} !== {eRf, WriteAdd, eWd}) begin err++; $display("FAIL rnd_rf n=%0d got %b %0d %h exp %b %0d %h", n, rf_wr, rf_wa, rf_wd, eRf, WriteAdd, eWd); end
      chk++; if (r7_wr !== eR7 || (eR7 && r7_wd !== eR7d)) begin err++; $display("FAIL rnd_r7 n=%0d got %b %h exp %b %h", n, r7_wr, r7_wd, eR7, eR7d); end
      if (wb_valid && CCRWrite) begin
        if (RegWriteSelect == 2'b01) mCcr[0] = (MemData == 0);
        else mCcr = CCR;
      end
      mFv = eRf;
      if (eRf) begin mFa = WriteAdd; mFd = eWd; end
      if (wb_valid) mCnt = mCnt + 1;
      tick();
      chk++; if ({ccr_q, fwd_valid, fwd_addr, fwd_data, retire_count} !== {mCcr, mFv, mFa, mFd, mCnt}) begin
        err++; $display("FAIL rnd_state n=%0d got %b %b %0d %h %h exp %b %b %0d %h %h", n, ccr_q, fwd_valid, fwd_addr, fwd_data, retire_count, mCcr, mFv, mFa, mFd, mCnt);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    wb_valid = 1;  // store-like: valid, no writes
    repeat (65535) @(posedge clk);
    #1;
    chk++; if (retire_count !== 16'hFFFF) begin err++; $display("FAIL wrap_pre got %h exp ffff", retire_count); end
    chk++; if ({rf_wr, r7_wr} !== 2'b00) begin err++; $display("FAIL wrap_wr got %b%b exp 00", rf_wr, r7_wr); end
    tick();
    chk++; if (retire_count !== 16'h0000) begin err++; $display("FAIL wrap_cnt got %h exp 0000", retire_count); end
    chk++; if (fwd_valid !== 1'b0) begin err++; $display("FAIL wrap_fwd got %b exp 0", fwd_valid); end
    idle();
  endtask

  initial begin
    reset = 1; idle();
    #1;
    test_reset();
    test_alu_write();
    test_load_zero();
    test_r7_redirect();
    test_bubble();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final-stage consumer of the fifth pipeline register's outputs; turns the registered WB bundle into register-file, R7/PC and flag updates.
- Owns the architectural condition-code register (carry, zero) and a one-entry write-back forwarding latch for decode-stage bypass.
- Keeps a wrapping count of retired instructions for bring-up and debug.
- Sits between the fifth pipeline register and the register file / PC-update logic.

Parameters:
- DW, 16, data width of all datapath values
- AW, 3, register address width (R0..R7)
- PC_REG, 7, register index that aliases the PC

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  WB bundle holds a real instruction; 0 means bubble
- MemData  in  DW  load data from the fifth pipeline register
- Imm970s  in  DW  immediate shifted into the upper bits (LHI value)
- PCImmInc  in  DW  PC plus immediate (branch/jump target)
- ALUOut  in  DW  ALU result
- PCInc  in  DW  PC plus one
- WriteAdd  in  AW  destination register
- WriteRF  in  1  register-file write request
- WriteR7  in  1  explicit R7/PC write request
- RegWriteSelect  in  2  RF data source: 00 ALUOut, 01 MemData, 10 Imm970s, 11 PCInc
- R7WriteSelect  in  3  R7 data source: 000 PCInc, 001 PCImmInc, 010 ALUOut, 011 MemData; 1xx behaves as 000
- CCR  in  2  upstream flags: [1] carry, [0] zero
- CCRWrite  in  1  flag update request
- rf_wr  out  1  register-file write enable, R0..R6 only
- rf_wa  out  AW  register-file write address
- rf_wd  out  DW  register-file write data
- r7_wr  out  1  PC/R7 write enable
- r7_wd  out  DW  PC/R7 write data
- ccr_q  out  2  architectural flags: [1] carry, [0] zero
- fwd_valid  out  1  forwarding latch holds a value
- fwd_addr  out  AW  forwarded register index
- fwd_data  out  DW  forwarded value
- retire_count  out  16  retired-instruction count

Behaviour:
- Reset: asynchronous, active-high. While reset is high: ccr_q=00, fwd_valid=0, fwd_addr=0, fwd_data=0, retire_count=0. The combinational write outputs are forced low: rf_wr=0, r7_wr=0.
- Write outputs are combinational, valid in the same cycle as the bundle. Registered state updates on the next rising edge.
- Write data: rf_wd = mux(RegWriteSelect). rf_wa = WriteAdd.
- rf_wr = wb_valid & WriteRF & (WriteAdd != PC_REG).
- R7 redirect: if wb_valid & WriteRF & (WriteAdd == PC_REG), then r7_wr=1 and r7_wd=rf_wd. This takes priority over WriteR7.
- Otherwise r7_wr = wb_valid & WriteR7 and r7_wd = mux(R7WriteSelect).
- Flags, when wb_valid & CCRWrite:
  - RegWriteSelect=01 (load): ccr_q[0] <= (MemData==0); ccr_q[1] holds.
  - Any other source: ccr_q <= CCR.
  - Flags hold otherwise.
- Forwarding latch:
  - When rf_wr=1: fwd_valid<=1, fwd_addr<=WriteAdd, fwd_data<=rf_wd.
  - When rf_wr=0: fwd_valid<=0, and addr/data hold.
  - The latch is visible exactly one cycle after the write.
  - An R7 write never loads the latch.
- retire_count increments on every cycle with wb_valid=1, including no-write instructions (stores, untaken branches). It wraps from FFFF to 0000.
- Bubble (wb_valid=0): no write, no flag change, no count.
- Reset asserted mid-operation: all state clears immediately; a bundle presented while reset is high is dropped.
- All arithmetic is unsigned. No saturation.

Decomposition:
- Shared package holds:
  - RegWriteSelect encodings: SEL_ALU, SEL_MEM, SEL_LHI, SEL_PCINC.
  - R7WriteSelect encodings: R7_PCINC, R7_TARGET, R7_ALU, R7_MEM.
  - Flag bit indices: CARRY_BIT=1, ZERO_BIT=0.
  - PC_REG.
- One natural sub-module: wb_flag_unit, which holds the CCR register and the load-zero logic. The muxes, forwarding latch and counter stay in the top level.

Test Plan:
- Reset: assert reset mid-stream with wb_valid=1 -> outputs go to reset values asynchronously, before the next edge; no write is observed.
- ALU write: WriteRF=1, WriteAdd=3, sel=00, ALUOut=0x1234, CCRWrite=1, CCR=10 -> rf_wr=1, rf_wa=3, rf_wd=0x1234 same cycle. Next cycle: ccr_q=10, fwd_valid=1, fwd_addr=3, fwd_data=0x1234.
- Load zero: prior ccr_q=10; sel=01, MemData=0x0000, CCRWrite=1 -> next cycle ccr_q=11. Then MemData=0x0005 -> ccr_q=10.
- R7 redirect: WriteRF=1, WriteAdd=7, sel=11, PCInc=0x0042, WriteR7=1, R7WriteSelect=001 -> rf_wr=0, r7_wr=1, r7_wd=0x0042; forwarding latch is not loaded.
- Bubble: wb_valid=0 with all write requests set -> rf_wr=0, r7_wr=0; ccr_q and retire_count unchanged; fwd_valid=0 next cycle.
- Wrap: retire_count at 0xFFFF plus one valid store (no writes) -> retire_count=0x0000, no RF or R7 activity.
